// File: rtl/puente_pkg.sv
// -----------------------------------------------------------------------------
// puente_pkg
// Shared definitions for the data-side memory/IO bridge:
//   - region_t        : address region selected by direc[31:12]
//   - *_BASE          : 4 KiB page numbers of each region
//   - IO_*            : I/O register offsets selected by direc[3:2]
//   - STATUS_*        : field positions inside the STATUS register
//   - decode_region() : maps the page number to a region
// -----------------------------------------------------------------------------
package puente_pkg;

  typedef enum logic [1:0] {
    REG_RAM   = 2'd0,
    REG_VIDEO = 2'd1,
    REG_IO    = 2'd2,
    REG_NONE  = 2'd3
  } region_t;

  localparam logic [19:0] RAM_BASE = 20'h00000;
  localparam logic [19:0] VID_BASE = 20'h00001;
  localparam logic [19:0] IO_BASE  = 20'h00002;

  localparam logic [1:0] IO_BTN    = 2'd0;
  localparam logic [1:0] IO_TIMER  = 2'd1;
  localparam logic [1:0] IO_STATUS = 2'd2;
  localparam logic [1:0] IO_LED    = 2'd3;

  // STATUS = {overflow at bit 8, fifo count at [7:0]}
  localparam int STATUS_OVF_BIT = 8;
  localparam int STATUS_CNT_W   = 8;

  function automatic region_t decode_region(input logic [19:0] page);
    region_t r;
    r = REG_NONE;
    if (page == RAM_BASE)      r = REG_RAM;
    else if (page == VID_BASE) r = REG_VIDEO;
    else if (page == IO_BASE)  r = REG_IO;
    return r;
  endfunction

endpackage

// File: rtl/puente_memoria_io_fifo.sv
// -----------------------------------------------------------------------------
// fifo_escritura
// Synchronous first-word fall-through FIFO used to post video writes.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : request to enqueue push_data
//   pop        : dequeue the head (ignored when empty)
//   head_data  : current head, read straight from storage
//   empty/full : occupancy flags
//   count      : entries held, 0..DEPTH
//   drop       : push refused this cycle (full and no pop)
// A push into a full FIFO is accepted only if the head leaves in the same
// cycle; the freed slot is exactly the one the write pointer addresses.
// -----------------------------------------------------------------------------
module fifo_escritura #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic do_push;
  logic do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign drop      = push & full & ~do_pop;
  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

  // Storage has no reset; stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/puente_memoria_io.sv
// -----------------------------------------------------------------------------
// puente_memoria_io
// Data-side bridge between a single-cycle core and its memories/peripherals.
// The core never stalls: reads are answered combinationally from registered
// state and video stores are posted into a small FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   memWr/direc/datoOut/datoIn : core data port (word accesses)
//   ramWr/ramDirec/ramDatoW/ramDatoR : data RAM port (region 0x00000xxx)
//   vidValid/vidReady/vidDirec/vidDato : video write stream (region 0x00001xxx)
//   btn               : raw asynchronous buttons (2-flop synchronized)
//   led               : LED register (IO region offset 0xC)
// IO region 0x00002xxx: 0x0 BTN, 0x4 TIMER, 0x8 STATUS, 0xC LED.
// -----------------------------------------------------------------------------
module puente_memoria_io
  import puente_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int VID_AW     = 12,
  parameter int PRESCALE   = 50000,
  parameter int N_BTN      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memWr,
  input  logic [31:0]       direc,
  input  logic [31:0]       datoOut,
  output logic [31:0]       datoIn,
  output logic              ramWr,
  output logic [9:0]        ramDirec,
  output logic [31:0]       ramDatoW,
  input  logic [31:0]       ramDatoR,
  output logic              vidValid,
  input  logic              vidReady,
  output logic [VID_AW-1:0] vidDirec,
  output logic [31:0]       vidDato,
  input  logic [N_BTN-1:0]  btn,
  output logic [7:0]        led
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  region_t    region;
  logic [1:0] io_sel;
  logic       wr_io;

  assign region = decode_region(direc[31:12]);
  assign io_sel = direc[3:2];
  assign wr_io  = memWr & (region == REG_IO);

  // Byte lane bits carry no information for word-only accesses.
  logic unused_direc;
  assign unused_direc = ^direc[1:0];

  // ------------------------------------------------------------- data RAM
  assign ramWr    = memWr & (region == REG_RAM);
  assign ramDirec = direc[11:2];
  assign ramDatoW = datoOut;

  // ----------------------------------------------------------- video FIFO
  logic          fifo_empty;
  logic          unused_fifo_full;
  logic [CW-1:0] fifo_count;
  logic          fifo_drop;

  fifo_escritura #(
    .DEPTH (FIFO_DEPTH),
    .W     (VID_AW + 32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (memWr & (region == REG_VIDEO)),
    .push_data ({direc[VID_AW+1:2], datoOut}),
    .pop       (vidValid & vidReady),
    .head_data ({vidDirec, vidDato}),
    .empty     (fifo_empty),
    .full      (unused_fifo_full),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign vidValid = ~fifo_empty;

  // ------------------------------------------------------ button synchronizer
  logic [N_BTN-1:0] btn_sync;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= btn[gi];
          sync_reg <= meta_reg;
        end
      end
      assign btn_sync[gi] = sync_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- timer
  logic [PW-1:0] presc_reg;
  logic [31:0]   tick_reg;

  // A software clear outranks the tick that would land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
      tick_reg  <= '0;
    end else if (wr_io && io_sel == IO_TIMER) begin
      presc_reg <= '0;
      tick_reg  <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
      tick_reg  <= tick_reg + 32'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // ------------------------------------------------- overflow flag and LEDs
  logic       ovf_reg;
  logic [7:0] led_reg;

  // A drop in the same cycle as a clear keeps the flag set so no loss is hidden.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (fifo_drop) begin
      ovf_reg <= 1'b1;
    end else if (wr_io && io_sel == IO_STATUS && datoOut[STATUS_OVF_BIT]) begin
      ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= 8'h00;
    end else if (wr_io && io_sel == IO_LED) begin
      led_reg <= datoOut[7:0];
    end
  end

  assign led = led_reg;

  // ------------------------------------------------------------ read mux
  logic [31:0] status_word;

  always_comb begin
    status_word = '0;
    status_word[STATUS_OVF_BIT] = ovf_reg;
    status_word[STATUS_CNT_W-1:0] = STATUS_CNT_W'(fifo_count);
  end

  always_comb begin
    datoIn = 32'h0;
    case (region)
      REG_RAM: datoIn = ramDatoR;
      REG_IO: begin
        case (io_sel)
          IO_BTN:    datoIn = 32'(btn_sync);
          IO_TIMER:  datoIn = tick_reg;
          IO_STATUS: datoIn = status_word;
          default:   datoIn = {24'h0, led_reg};
        endcase
      end
      default: datoIn = 32'h0;
    endcase
  end

endmodule
